con_ff_sequencer: RTL
=====================

// Module: con_ff_sequencer
// PURPOSE
//  Sequences the conditional-branch CON flip-flop for br-class instructions.
//  Control unit pulses start with IR[20:19] (condition code); block waits for the Ra value on the bus,
//  evaluates the condition, updates con_ff, pulses done. Sits between the control unit, the bus and PC-load logic.
// PARAMETERS
//  DATA_W   32  width of bus_data / evaluated register value
//  TIMEOUT  8   max cycles in WAIT_BUS before abort (>=1)
//  CNT_W    16  width of saturating taken-branch counter
// PORTS
//  clk           in   1        system clock, rising edge
//  clr           in   1        asynchronous, active-high reset
//  start         in   1        1-cycle request from control unit (accepted only in IDLE)
//  ir_cond       in   2        IR[20:19]: 00 zero, 01 nonzero, 10 positive, 11 negative
//  bus_data      in   DATA_W   Ra value driven on bus
//  bus_valid     in   1        bus_data valid this cycle
//  busy          out  1        high in any state except IDLE
//  done          out  1        1-cycle pulse, evaluation finished
//  con_ff        out  1        registered branch-condition result to PC-load logic
//  timeout_err   out  1        1-cycle pulse coincident with done when WAIT_BUS timed out
//  taken_cnt     out  CNT_W    saturating count of evaluations with con_ff=1
// BEHAVIOUR
//  Reset (clr=1, any time, async): state=IDLE; busy=0, done=0, con_ff=0, timeout_err=0, taken_cnt=0,
//   cond_q=0, data_q=0, timer=0. Reset mid-operation abandons evaluation, no done pulse.
//  FSM states: IDLE, WAIT_BUS, EVAL, DONE.
//   IDLE: start=1 -> latch cond_q<=ir_cond, timer<=0, go WAIT_BUS. Else stay.
//   WAIT_BUS: bus_valid=1 -> data_q<=bus_data, go EVAL (bus_valid wins over timeout in same cycle).
//    else timer++; timer==TIMEOUT-1 -> set to_flag, go DONE.
//   EVAL: con_ff<=eval(cond_q,data_q); taken_cnt++ if result 1 (saturates at all-ones); go DONE.
//   DONE: done=1 for exactly this cycle; timeout_err=to_flag; to_flag cleared; go IDLE.
//  Timeout path: con_ff<=0 on WAIT_BUS->DONE transition; taken_cnt unchanged.
//  Condition eval (unsigned bit tests on data_q):
//   00 brzr: data_q==0; 01 brnz: data_q!=0; 10 brpl: data_q[DATA_W-1]==0; 11 brmi: data_q[DATA_W-1]==1.
//  Latency: start -> WAIT_BUS next edge; bus_valid sampled at edge N -> con_ff valid and done=1
//   after edge N+2 (EVAL at N+1, DONE at N+2). Min start-to-done: 3 cycles.
//  con_ff holds its value between evaluations; changes only in EVAL or on timeout.
//  start while busy=1: ignored, no queueing. ir_cond sampled only on accepted start.
//  bus_valid outside WAIT_BUS ignored. busy=1 in WAIT_BUS, EVAL, DONE.
//  All outputs registered or decoded from state register only; no combinational path input->output.
// STRUCTURE
//  Shared package: condition-code localparams (COND_ZR=2'b00, COND_NZ=2'b01, COND_PL=2'b10,
//   COND_MI=2'b11) and FSM state encoding (2-bit).
//  Sub-module con_eval: combinational (cond[1:0], data[DATA_W-1:0]) -> result, one-hot decode of cond
//   ANDed with zero / nonzero / sign tests. FSM, timer and counter stay in top.
// TESTING
//  1 clr mid-WAIT_BUS after start -> busy=0 immediately, no done, con_ff=0, taken_cnt=0.
//  2 start ir_cond=00, bus_valid with bus_data=0 -> done 2 cycles later, con_ff=1, taken_cnt=1;
//    repeat with 0x00000005 -> con_ff=0, taken_cnt stays 1.
//  3 ir_cond=10 with 0x7FFFFFFF -> con_ff=1; ir_cond=11 with 0x80000000 -> con_ff=1;
//    ir_cond=10 with 0x80000000 -> con_ff=0; ir_cond=01 with 0x1 -> con_ff=1.
//  4 start, never assert bus_valid, TIMEOUT=8 -> done + timeout_err on same cycle after 8 WAIT_BUS
//    cycles, con_ff=0; bus_valid on the 8th cycle instead -> normal EVAL, no timeout_err.
//  5 start pulses during WAIT_BUS/EVAL/DONE with different ir_cond -> ignored; result uses first cond_q.
//  6 CNT_W=4, 17 taken evaluations -> taken_cnt saturates at 4'hF, no wrap.

Source files
------------

// File: rtl/con_ff_sequencer_pkg.sv
// Shared definitions for the CON flip-flop sequencer:
// branch condition codes and FSM state encoding.
package con_ff_sequencer_pkg;

  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_EVAL = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/con_ff_sequencer_eval.sv
// Combinational branch-condition evaluator: one-hot
// condition select ANDed with zero / nonzero / sign tests.
module con_eval
  import con_ff_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        cond,
  input  logic [DATA_W-1:0] data,
  output logic              result
);

  logic [3:0] sel;
  logic [3:0] hit;
  logic       zero;

  always_comb begin
    sel = 4'b0000;
    unique case (cond)
      COND_ZR: sel = 4'b0001;
      COND_NZ: sel = 4'b0010;
      COND_PL: sel = 4'b0100;
      COND_MI: sel = 4'b1000;
    endcase
  end

  assign zero   = ~|data;
  assign hit    = {data[DATA_W-1], ~data[DATA_W-1], ~zero, zero};
  assign result = |(sel & hit);

endmodule

// File: rtl/con_ff_sequencer.sv
// Sequences the CON flip-flop for br-class instructions:
// waits for Ra on the bus, evaluates, pulses done.
module con_ff_sequencer
  import con_ff_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [1:0]        ir_cond,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              bus_valid,
  output logic              busy,
  output logic              done,
  output logic              con_ff,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [1:0]        cond_q;
  logic [DATA_W-1:0] data_q;
  logic [TW-1:0]     timer;
  logic              to_flag;
  logic              result;
  logic              expire;

  con_eval #(
    .DATA_W(DATA_W)
  ) u_eval (
    .cond  (cond_q),
    .data  (data_q),
    .result(result)
  );

  // valid data on the bus takes priority over a timer expiry
  assign expire = (state == S_WAIT) && !bus_valid && (timer == TLAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_WAIT;
      S_WAIT: begin
        if (bus_valid)   state_nx = S_EVAL;
        else if (expire) state_nx = S_DONE;
      end
      S_EVAL: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    timeout_err = (state == S_DONE) && to_flag;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cond_q    <= '0;
      data_q    <= '0;
      timer     <= '0;
      to_flag   <= 1'b0;
      con_ff    <= 1'b0;
      taken_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cond_q <= ir_cond;
            timer  <= '0;
          end
        end
        S_WAIT: begin
          if (bus_valid) begin
            data_q <= bus_data;
          end else begin
            timer <= timer + TW'(1);
            if (expire) begin
              to_flag <= 1'b1;
              con_ff  <= 1'b0;
            end
          end
        end
        S_EVAL: begin
          con_ff <= result;
          if (result && (taken_cnt != '1))
            taken_cnt <= taken_cnt + CNT_W'(1);
        end
        S_DONE: to_flag <= 1'b0;
      endcase
    end
  end

endmodule
